// File: rtl/kernel_window_reader.sv
// kernel_window_reader: sweeps one frame of the 3-bank line-interleaved binary buffer and streams 3x3 kernels.
// Optional ZERO_PAD_EN: out-of-frame neighbours read as 0 instead of replicating the frame edge.
module kernel_window_reader #(
    parameter int H_PIX  = 320,
    parameter int V_PIX  = 240,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        frame_sel,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [ADDR_W-1:0] rd_addr_c,
    input  logic              rd_data_a,
    input  logic              rd_data_b,
    input  logic              rd_data_c,
    output logic [8:0]        kernel_out,
    output logic [8:0]        kernel_x,
    output logic [7:0]        kernel_y,
    output logic              kernel_valid,
    input  logic              kernel_ready,
    output logic              busy,
    output logic              frame_done
);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int ROWS_PER_BANK = V_PIX / 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic logic [1:0] bank_of(input logic [7:0] row);
        bank_of = 2'(row % 8'd3);
    endfunction

    // frame_sel 3 aliases slot 0
    function automatic logic [ADDR_W-1:0] row_addr(input logic [1:0] fsel, input logic [7:0] row,
                                                   input logic [8:0] col);
        logic [ADDR_W-1:0] base;
        if (fsel == 2'd3) base = '0;
        else base = ADDR_W'(fsel) * ADDR_W'(ROWS_PER_BANK * H_PIX);
        row_addr = base + ADDR_W'(row / 8'd3) * ADDR_W'(H_PIX) + ADDR_W'(col);
    endfunction

    // Column vectors are indexed 0=top, 1=mid, 2=bottom; rmask clears whole rows.
    function automatic logic [8:0] assemble(input logic [2:0] l, input logic [2:0] c,
                                            input logic [2:0] r, input logic [2:0] rmask);
        logic [8:0] k;
        for (int i = 0; i < 3; i++) begin
            k[3*i]   = l[i] & rmask[i];
            k[3*i+1] = c[i] & rmask[i];
            k[3*i+2] = r[i] & rmask[i];
        end
        assemble = k;
    endfunction

    state_t                   state_q, state_d;
    logic [8:0]               x_q, x_d;
    logic [7:0]               y_q, y_d;
    logic [1:0]               fsel_q, fsel_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     prime_q, prime_d;
    logic [2:0]               col_l_q, col_l_d, col_c_q, col_c_d, col_r_q, col_r_d;
    logic [2:0][ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]               kernel_q, kernel_d;
    logic                     valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic [2:0][7:0]          rows_s;
    logic [8:0]               fetch_col_s;
    logic [2:0]               sample_s, left_s, right_s, rmask_s;
    logic [8:0]               kern_s;

    // Clamped source rows, fetch column, bank-to-row routing and the kernel formed at capture.
    always_comb begin
        if (y_q == 8'd0) rows_s[0] = 8'd0;
        else rows_s[0] = y_q - 8'd1;
        rows_s[1] = y_q;
        if (y_q == 8'(V_PIX - 1)) rows_s[2] = y_q;
        else rows_s[2] = y_q + 8'd1;

        if (prime_q) fetch_col_s = 9'd0;
        else if (x_q == 9'(H_PIX - 1)) fetch_col_s = x_q;
        else fetch_col_s = x_q + 9'd1;

        for (int i = 0; i < 3; i++) begin
            case (bank_of(rows_s[i]))
                2'd0:    sample_s[i] = rd_data_a;
                2'd1:    sample_s[i] = rd_data_b;
                2'd2:    sample_s[i] = rd_data_c;
                default: sample_s[i] = 1'b0;
            endcase
        end

        left_s  = col_l_q;
        right_s = sample_s;
        rmask_s = 3'b111;
`ifdef ZERO_PAD_EN
        if (x_q == 9'd0) left_s = 3'd0;
        else left_s = col_l_q;
        if (x_q == 9'(H_PIX - 1)) right_s = 3'd0;
        else right_s = sample_s;
        if (y_q == 8'd0) rmask_s[0] = 1'b0;
        else rmask_s[0] = 1'b1;
        if (y_q == 8'(V_PIX - 1)) rmask_s[2] = 1'b0;
        else rmask_s[2] = 1'b1;
`endif
        kern_s = assemble(left_s, col_c_q, right_s, rmask_s);
    end

    // Sweep FSM: next state, window shifting, address issue and handshake outputs.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        fsel_d   = fsel_q;
        cnt_d    = cnt_q;
        prime_d  = prime_q;
        col_l_d  = col_l_q;
        col_c_d  = col_c_q;
        col_r_d  = col_r_q;
        addr_d   = addr_q;
        kernel_d = kernel_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    fsel_d  = frame_sel;
                    x_d     = 9'd0;
                    y_d     = 8'd0;
                    busy_d  = 1'b1;
                    prime_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // Rows sharing a bank are the same clamped row, so they agree on the address.
                for (int i = 0; i < 3; i++) begin
                    case (bank_of(rows_s[i]))
                        2'd0:    addr_d[0] = row_addr(fsel_q, rows_s[i], fetch_col_s);
                        2'd1:    addr_d[1] = row_addr(fsel_q, rows_s[i], fetch_col_s);
                        2'd2:    addr_d[2] = row_addr(fsel_q, rows_s[i], fetch_col_s);
                        default: addr_d    = addr_q;
                    endcase
                end
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = CAPTURE;
                else cnt_d = cnt_q + 1'b1;
            end
            CAPTURE: begin
                if (prime_q) begin
                    col_l_d = sample_s;
                    col_c_d = sample_s;
                    prime_d = 1'b0;
                    state_d = ISSUE;
                end else begin
                    col_r_d  = sample_s;
                    kernel_d = kern_s;
                    valid_d  = 1'b1;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (kernel_ready) begin
                    valid_d = 1'b0;
                    if (x_q == 9'(H_PIX - 1)) begin
                        if (y_q == 8'(V_PIX - 1)) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            x_d     = 9'd0;
                            y_d     = y_q + 8'd1;
                            prime_d = 1'b1;
                            state_d = ISSUE;
                        end
                    end else begin
                        col_l_d = col_c_q;
                        col_c_d = col_r_q;
                        x_d     = x_q + 9'd1;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that clears outputs and window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= 9'd0;
            y_q      <= 8'd0;
            fsel_q   <= 2'd0;
            cnt_q    <= '0;
            prime_q  <= 1'b0;
            col_l_q  <= 3'd0;
            col_c_q  <= 3'd0;
            col_r_q  <= 3'd0;
            addr_q   <= '0;
            kernel_q <= 9'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fsel_q   <= fsel_d;
            cnt_q    <= cnt_d;
            prime_q  <= prime_d;
            col_l_q  <= col_l_d;
            col_c_q  <= col_c_d;
            col_r_q  <= col_r_d;
            addr_q   <= addr_d;
            kernel_q <= kernel_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign rd_addr_a    = addr_q[0];
    assign rd_addr_b    = addr_q[1];
    assign rd_addr_c    = addr_q[2];
    assign kernel_out   = kernel_q;
    assign kernel_x     = x_q;
    assign kernel_y     = y_q;
    assign kernel_valid = valid_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
endmodule

// File: tb/tb_kernel_window_reader.sv
// Scoreboard bench for kernel_window_reader on a reduced 16x9 frame: a pixel-array reference model
// predicts each kernel and its fetch addresses; a negedge monitor pops and compares on every handshake.
module tb_kernel_window_reader;
    localparam int H  = 16;
    localparam int V  = 9;
    localparam int AW = 17;
    localparam int RL = 2;

    logic          clk, reset, start, kernel_ready;
    logic [1:0]    frame_sel;
    logic [AW-1:0] rd_addr_a, rd_addr_b, rd_addr_c;
    logic          rd_data_a, rd_data_b, rd_data_c;
    logic [8:0]    kernel_out, kernel_x;
    logic [7:0]    kernel_y;
    logic          kernel_valid, busy, frame_done;

    kernel_window_reader #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_sel(frame_sel),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
        .kernel_out(kernel_out), .kernel_x(kernel_x), .kernel_y(kernel_y),
        .kernel_valid(kernel_valid), .kernel_ready(kernel_ready),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        int         fs;
        logic [8:0] k;
    } exp_t;

    bit   pix [3][V][H];
    exp_t exp_q [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    int   stall_x = -1;
    int   stall_y = -1;
    bit   stall_pending = 1'b0;
    logic [2:0] stage1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // Bank memory: bank b, word w holds pixel (w%H) of row ((w/H)%(V/3))*3+b of frame w/(H*V/3).
    function automatic bit bank_bit(input int b, input logic [AW-1:0] addr);
        int a, fs, rem;
        a   = int'(addr);
        fs  = a / ((V / 3) * H);
        rem = a % ((V / 3) * H);
        if (fs > 2) return 1'b0;
        return pix[fs][(rem / H) * 3 + b][rem % H];
    endfunction

    always @(posedge clk) begin
        stage1 <= {bank_bit(2, rd_addr_c), bank_bit(1, rd_addr_b), bank_bit(0, rd_addr_a)};
        {rd_data_c, rd_data_b, rd_data_a} <= stage1;
    end

    function automatic logic [8:0] ref_kernel(input int fs, input int x, input int y);
        logic [8:0] k;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int yy, xx;
                yy = y + r - 1;
                xx = x + c - 1;
`ifdef ZERO_PAD_EN
                if (yy < 0 || yy >= V || xx < 0 || xx >= H) k[3*r+c] = 1'b0;
                else k[3*r+c] = pix[fs][yy][xx];
`else
                if (yy < 0) yy = 0;
                if (yy >= V) yy = V - 1;
                if (xx < 0) xx = 0;
                if (xx >= H) xx = H - 1;
                k[3*r+c] = pix[fs][yy][xx];
`endif
            end
        end
        return k;
    endfunction

    // Monitor: compare each accepted kernel and its right-column fetch addresses.
    always @(negedge clk) begin
        if (!reset && kernel_valid && kernel_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_kernel", 64'(kernel_x), 64'(999));
            end else begin
                mon_e = exp_q.pop_front();
                check("kernel_x", 64'(kernel_x), 64'(mon_e.x));
                check("kernel_y", 64'(kernel_y), 64'(mon_e.y));
                check($sformatf("kernel_out(%0d,%0d)", mon_e.x, mon_e.y), 64'(kernel_out), 64'(mon_e.k));
                for (int i = 0; i < 3; i++) begin
                    int row, col, ea;
                    logic [AW-1:0] act;
                    row = mon_e.y + i - 1;
                    if (row < 0) row = 0;
                    if (row > V - 1) row = V - 1;
                    col = (mon_e.x + 1 > H - 1) ? H - 1 : mon_e.x + 1;
                    ea  = mon_e.fs * (V / 3) * H + (row / 3) * H + col;
                    act = (row % 3 == 0) ? rd_addr_a : (row % 3 == 1) ? rd_addr_b : rd_addr_c;
                    check($sformatf("rd_addr(%0d,%0d) row%0d", mon_e.x, mon_e.y, row), 64'(act), 64'(ea));
                end
            end
        end
        if (!reset && frame_done) begin
            done_cnt++;
            check("done_after_last_kernel", 64'(exp_q.size()), 64'(0));
        end
    end

    // Ready driver: always-on or random, with one optional 20-cycle stall at a chosen kernel.
    initial begin
        logic [8:0]  sk;
        logic [AW-1:0] sa, sb, sc;
        bit stable;
        kernel_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_pending && kernel_valid && int'(kernel_x) == stall_x && int'(kernel_y) == stall_y) begin
                stall_pending = 1'b0;
                kernel_ready  = 1'b0;
                sk = kernel_out; sa = rd_addr_a; sb = rd_addr_b; sc = rd_addr_c;
                stable = 1'b1;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (kernel_valid !== 1'b1 || kernel_out !== sk || int'(kernel_x) != stall_x ||
                        int'(kernel_y) != stall_y || rd_addr_a !== sa || rd_addr_b !== sb || rd_addr_c !== sc)
                        stable = 1'b0;
                end
                check("stall_outputs_stable", 64'(stable), 64'(1));
                kernel_ready = 1'b1;
            end else if (ready_mode == 0) begin
                kernel_ready = 1'b1;
            end else begin
                kernel_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic begin_frame(input int fs, input bit lat_chk);
        int efs, n;
        efs = (fs == 3) ? 0 : fs;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                exp_q.push_back('{x: x, y: y, fs: efs, k: ref_kernel(efs, x, y)});
        done_cnt  = 0;
        frame_sel = 2'(fs);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        frame_sel = 2'($urandom_range(0, 3));
        check("busy_after_start", 64'(busy), 64'(1));
        if (lat_chk) begin
            n = 0;
            while (!kernel_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            check("first_valid_latency", 64'(n), 64'(2 * (RL + 2)));
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_done_seen", 64'(done_cnt > 0), 64'(1));
        repeat (10) @(posedge clk);
        #1;
        check("frame_done_count", 64'(done_cnt), 64'(1));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("busy_low_after_frame", 64'(busy), 64'(0));
        exp_q.delete();
    endtask

    task automatic fill(input int fs, input int mode);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                pix[fs][y][x] = (mode == 1) ? 1'b1 : (mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; frame_sel = 2'd0;
        for (int f = 0; f < 3; f++) fill(f, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_valid", 64'(kernel_valid), 64'(0));
        check("reset_done", 64'(frame_done), 64'(0));
        check("reset_kernel", 64'(kernel_out), 64'(0));
        check("reset_xy", 64'({kernel_x, kernel_y}), 64'(0));
        check("reset_addr", 64'({rd_addr_a, rd_addr_b, rd_addr_c}), 64'(0));
        reset = 1'b0;

        // All-ones frame with ready held high, including first-kernel latency.
        fill(0, 1);
        ready_mode = 0;
        begin_frame(0, 1'b1);
        wait_frame();

        // Single set pixel at the top-left corner, random backpressure.
        fill(1, 0);
        pix[1][0][0] = 1'b1;
        ready_mode = 1;
        begin_frame(1, 1'b0);
        wait_frame();

        // Single set pixel at the bottom-right corner.
        fill(0, 0);
        pix[0][V-1][H-1] = 1'b1;
        ready_mode = 0;
        begin_frame(0, 1'b0);
        wait_frame();

        // Random frame 2 with a stray start selecting frame 1 mid-sweep.
        fill(1, 2);
        fill(2, 2);
        ready_mode = 1;
        begin_frame(2, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        frame_sel = 2'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_through_stray_start", 64'(busy), 64'(1));
        wait_frame();

        // Random frame with a 20-cycle ready stall at kernel (10,5).
        stall_x = 10; stall_y = 5; stall_pending = 1'b1;
        begin_frame(1, 1'b0);
        wait_frame();
        check("stall_taken", 64'(stall_pending), 64'(0));

        // Reset mid-frame at kernel (6,3), then restart with frame_sel=3 (slot 0).
        fill(0, 2);
        begin_frame(0, 1'b0);
        n = 0;
        while (!(kernel_valid && kernel_x == 9'd6 && kernel_y == 8'd3) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_reset_point", 64'(n < 5000), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_valid", 64'(kernel_valid), 64'(0));
        check("midreset_addr", 64'({rd_addr_a, rd_addr_b, rd_addr_c}), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        begin_frame(3, 1'b0);
        wait_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
